// File: rtl/spi_reg_peripheral.sv
// spi_reg_peripheral
//   Write-only SPI (mode 0) peripheral that holds the five 8-bit control
//   registers consumed by the PWM peripheral. The SPI pins are asynchronous
//   to clk, so they are synchronized and edge-detected here.
//
//   Frame layout, MSB first: [15]=R/W (1=write), [14:8]=addr, [7:0]=data.
//   A frame commits when ncs rises after exactly FRAME_BITS sclk rises. Reads
//   and out-of-range addresses are dropped silently. Any other bit count is
//   dropped and pulses frame_err for one clk.
//
// Ports
//   clk, rst_n         system clock, async active-low reset
//   sclk, copi, ncs    SPI pins from the controller (async)
//   en_reg_out_7_0     reg 0x00      en_reg_out_15_8  reg 0x01
//   en_reg_pwm_7_0     reg 0x02      en_reg_pwm_15_8  reg 0x03
//   pwm_duty_cycle     reg 0x04
//   frame_err          one-clk pulse when a frame has a bad length
module spi_reg_peripheral #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       frame_err
);

  localparam int unsigned CW    = $clog2(FRAME_BITS + 2);
  localparam int unsigned AW    = FRAME_BITS - 9;
  localparam int unsigned NREGS = 5;

  // Synchronizers: bit 0 takes the pin, bit SYNC_STAGES-1 is the synced value.
  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic                   sclk_hist_q, ncs_hist_q;

  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NREGS-1:0][7:0]  regs_q, regs_d;
  logic                   frame_err_q, frame_err_d;

  logic          sclk_s, copi_s, ncs_s;
  logic          sclk_rise, ncs_rise, ncs_fall;
  logic          rw_w;
  logic [AW-1:0] addr_w;
  logic [7:0]    data_w;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign ncs_rise  = ncs_s & ~ncs_hist_q;
  assign ncs_fall  = ~ncs_s & ncs_hist_q;

  assign rw_w   = shift_q[FRAME_BITS-1];
  assign addr_w = shift_q[FRAME_BITS-2:8];
  assign data_w = shift_q[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_hist_q <= 1'b0;
      ncs_hist_q  <= 1'b1;
      shift_q     <= '0;
      cnt_q       <= '0;
      regs_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      sclk_hist_q <= sclk_s;
      ncs_hist_q  <= ncs_s;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      regs_q      <= regs_d;
      frame_err_q <= frame_err_d;
    end
  end

  // ncs edges take priority over a coincident sclk rise: a falling ncs
  // restarts the count, a rising ncs closes the frame before any new bit.
  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    regs_d      = regs_q;
    frame_err_d = 1'b0;
    if (ncs_fall) begin
      cnt_d = '0;
    end else if (ncs_rise) begin
      if (cnt_q == CW'(FRAME_BITS)) begin
        if (rw_w && (addr_w <= AW'(MAX_ADDR))) begin
          for (int unsigned i = 0; i < NREGS; i++) begin
            if (addr_w == AW'(i)) regs_d[i] = data_w;
          end
        end
      end else begin
        frame_err_d = 1'b1;
      end
    end else if (!ncs_s && sclk_rise) begin
      shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
      if (cnt_q != CW'(FRAME_BITS + 1)) cnt_d = cnt_q + CW'(1);
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
  assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_spi_reg_peripheral.sv
module tb_spi_reg_peripheral;

  localparam int PH = 4;  // clk periods per SPI phase / ncs setup-hold

  logic       clk = 1'b0;
  logic       rst_n, sclk, copi, ncs;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       frame_err;

  spi_reg_peripheral #(.SYNC_STAGES(2), .FRAME_BITS(16), .MAX_ADDR(4)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  logic [4:0][7:0] dut_r;
  assign dut_r = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
                  en_reg_out_15_8, en_reg_out_7_0};

  // Counts clk cycles in which frame_err is high (so pulse width is visible).
  int err_total = 0;
  always @(negedge clk) if (frame_err === 1'b1) err_total++;

  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0][7:0] cur_exp;  // registers the bench expects right now
  logic [4:0][7:0] model_r;  // reference register file for random frames

  typedef struct {
    logic [31:0]     bits;
    int              nbits;
    logic [4:0][7:0] exp;
    logic            err;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: a well-formed 16-bit write to addr 0..4 replaces that byte;
  // reads and higher addresses are dropped; any other length is an error.
  function automatic logic [40:0] model_next(input logic [4:0][7:0] r,
                                             input logic [31:0] bits, input int nbits);
    logic [4:0][7:0] n;
    logic [6:0]      a;
    logic            e;
    n = r;
    e = 1'b0;
    a = bits[14:8];
    if (nbits != 16) e = 1'b1;
    else if (bits[15] && a <= 7'd4) n[a] = bits[7:0];
    return {e, n};
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bits(input logic [31:0] bits, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = bits[i];
      wait_clk(PH);
      sclk = 1'b1;
      wait_clk(PH);
      sclk = 1'b0;
    end
  endtask

  // One transaction; simult puts an sclk rise on the same clk as both the
  // ncs fall and the ncs rise, neither of which may be counted as a bit.
  task automatic send_and_check(input string tag, input logic [31:0] bits, input int nbits,
                                input logic [4:0][7:0] exp, input logic exp_err,
                                input bit simult);
    int base;
    if (simult) begin
      copi = 1'b1; ncs = 1'b0; sclk = 1'b1;
      wait_clk(PH);
      sclk = 1'b0;
    end else begin
      ncs = 1'b0;
    end
    wait_clk(PH);
    drive_bits(bits, nbits);
    wait_clk(PH);
    base = err_total;
    if (simult) begin
      copi = 1'b1; sclk = 1'b1;
    end
    ncs = 1'b1;
    wait_clk(2);
    chk({tag, " regs before commit edge"}, 64'(dut_r), 64'(cur_exp));
    wait_clk(1);
    chk({tag, " regs after ncs rise"}, 64'(dut_r), 64'(exp));
    sclk = 1'b0;
    wait_clk(PH + 1);
    chk({tag, " frame_err cycles"}, 64'(err_total - base), 64'(exp_err));
    chk({tag, " regs hold"}, 64'(dut_r), 64'(exp));
    cur_exp = exp;
  endtask

  task automatic send_model(input string tag, input logic [31:0] bits, input int nbits,
                            input bit simult);
    logic [40:0] r;
    r = model_next(model_r, bits, nbits);
    model_r = r[39:0];
    send_and_check(tag, bits, nbits, r[39:0], r[40], simult);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h80F0,  16, 40'h00_00_00_00_F0, 1'b0};
    tbl[1] = '{32'h8480,  16, 40'h80_00_00_00_F0, 1'b0};
    tbl[2] = '{32'h820F,  16, 40'h80_00_0F_00_F0, 1'b0};
    tbl[3] = '{32'h0455,  16, 40'h80_00_0F_00_F0, 1'b0};
    tbl[4] = '{32'h8555,  16, 40'h80_00_0F_00_F0, 1'b0};
    tbl[5] = '{32'h40D5,  15, 40'h80_00_0F_00_F0, 1'b1};
    tbl[6] = '{32'h10354, 17, 40'h80_00_0F_00_F0, 1'b1};

    rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    cur_exp = '0;
    wait_clk(3);
    chk("reset regs", 64'(dut_r), 64'h0);
    chk("reset frame_err", 64'(frame_err), 64'h0);
    rst_n = 1'b1;
    wait_clk(3);

    for (int i = 0; i < 7; i++)
      send_and_check($sformatf("tbl%0d", i), tbl[i].bits, tbl[i].nbits,
                     tbl[i].exp, tbl[i].err, 1'b0);
    model_r = cur_exp;

    // sclk activity while deselected must be ignored
    begin
      int base;
      base = err_total;
      for (int i = 0; i < 6; i++) begin
        copi = 1'($urandom);
        sclk = 1'b1; wait_clk(PH);
        sclk = 1'b0; wait_clk(PH);
      end
      chk("idle sclk regs", 64'(dut_r), 64'(cur_exp));
      chk("idle sclk frame_err", 64'(err_total - base), 64'h0);
    end
    send_model("w3", 32'h8333, 16, 1'b0);
    send_model("simult", 32'h8211, 16, 1'b1);

    // reset in the middle of a frame
    ncs = 1'b0;
    wait_clk(PH);
    drive_bits(32'h81, 8);
    rst_n = 1'b0;
    wait_clk(1);
    chk("midframe reset regs", 64'(dut_r), 64'h0);
    chk("midframe reset frame_err", 64'(frame_err), 64'h0);
    ncs = 1'b1; sclk = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    model_r = '0;
    cur_exp = '0;
    chk("after reset regs", 64'(dut_r), 64'h0);
    send_model("post-reset", 32'h81AA, 16, 1'b0);

    for (int k = 0; k < 24; k++) begin
      logic [31:0] b;
      int          nb;
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 20)) : 16;
      if (nb == 16)
        b = {16'h0, 1'($urandom_range(0, 4) != 0), 7'($urandom_range(0, 6)), 8'($urandom)};
      else
        b = $urandom & ((32'h1 << nb) - 32'h1);
      send_model($sformatf("rand%0d", k), b, nb, 1'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
